// File: rtl/cache_ctrl.sv
// cache_ctrl: four-line, fully associative, write-back cache controller.
// Hits complete in two cycles. Misses optionally write back a dirty victim,
// then fill the line from backing memory. All outputs are registered.
// Build option: define CACHE_LRU_EN for true-LRU replacement. Without it the
// controller uses a round-robin victim pointer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready, waiting for req
// LOOKUP   | compare the latched address against all valid tags
// WB       | write-back strobe for a dirty victim
// FILL     | read strobe to backing memory
// CAPTURE  | backing data present on mem_dado, written into the victim line
// DONE     | completion pulse, then back to IDLE
module cache_ctrl #(
    parameter int LINES  = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              hit,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco_wb,
    output logic [DATA_W-1:0] mem_dado_wb,
    output logic              mem_wb
);
    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_FILL, S_CAPTURE, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [IDX_W-1:0]  idx_q;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [ADDR_W-1:0] tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    logic              ready_q, done_q, hit_out_q, mem_read_q, mem_wb_q;
    logic [DATA_W-1:0] rdata_q, mem_dado_wb_q;
    logic [ADDR_W-1:0] mem_endereco_q, mem_endereco_wb_q;

    logic              hit_any, inv_any;
    logic [IDX_W-1:0]  hit_idx, inv_idx, repl_idx, victim_idx;

    logic              upd_en;
    logic [IDX_W-1:0]  upd_idx;
    logic [DATA_W-1:0] upd_data;
    logic              upd_dirty;

    assign ready           = ready_q;
    assign done            = done_q;
    assign hit             = hit_out_q;
    assign rdata           = rdata_q;
    assign mem_read        = mem_read_q;
    assign mem_endereco    = mem_endereco_q;
    assign mem_wb          = mem_wb_q;
    assign mem_endereco_wb = mem_endereco_wb_q;
    assign mem_dado_wb     = mem_dado_wb_q;

    // Tag match and lowest-index invalid line (descending scan, lowest wins).
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == addr_q)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
    end

`ifdef CACHE_LRU_EN
    localparam logic [1:0] AGE_MAX = 2'(LINES - 1);

    logic [1:0] age_q [LINES];
    logic [1:0] old_age;

    // LRU victim: the line whose age has reached the maximum.
    always_comb begin
        repl_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (age_q[i] == AGE_MAX) begin
                repl_idx = IDX_W'(i);
            end
        end
    end

    // A line that was invalid before its fill counts as the oldest, so every
    // valid line ages by one and the ages stay a permutation of 0..n-1.
    assign old_age = valid_q[upd_idx] ? age_q[upd_idx] : AGE_MAX;

    // Age update on each completed access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < LINES; j++) begin
                age_q[j] <= '0;
            end
        end else if (upd_en) begin
            for (int j = 0; j < LINES; j++) begin
                if (IDX_W'(j) == upd_idx) begin
                    age_q[j] <= '0;
                end else if (valid_q[j] && (age_q[j] < old_age)) begin
                    age_q[j] <= age_q[j] + 2'd1;
                end
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q;

    assign repl_idx = ptr_q;

    // Round-robin pointer advances only when a miss had to evict a valid line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if ((state_q == S_LOOKUP) && !hit_any && !inv_any) begin
            ptr_q <= ptr_q + IDX_W'(1);
        end
    end
`endif

    assign victim_idx = inv_any ? inv_idx : repl_idx;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (hit_any) begin
                    state_d = S_DONE;
                end else if (valid_q[victim_idx] && dirty_q[victim_idx]) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WB:      state_d = S_FILL;
            S_FILL:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Line update applied on the edge entering DONE, so the registered rdata
    // already reflects the access (fill data, then any write on top).
    always_comb begin
        upd_en    = 1'b0;
        upd_idx   = idx_q;
        upd_data  = mem_dado;
        upd_dirty = we_q;
        if ((state_q == S_LOOKUP) && hit_any) begin
            upd_en    = 1'b1;
            upd_idx   = hit_idx;
            upd_data  = we_q ? wdata_q : data_q[hit_idx];
            upd_dirty = dirty_q[hit_idx] | we_q;
        end else if (state_q == S_CAPTURE) begin
            upd_en    = 1'b1;
            upd_data  = we_q ? wdata_q : mem_dado;
            upd_dirty = we_q;
        end
    end

    // State register and request latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == S_LOOKUP) begin
                idx_q <= hit_any ? hit_idx : victim_idx;
            end
        end
    end

    // Line storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int j = 0; j < LINES; j++) begin
                tag_q[j]  <= '0;
                data_q[j] <= '0;
            end
        end else if (upd_en) begin
            data_q[upd_idx]  <= upd_data;
            dirty_q[upd_idx] <= upd_dirty;
            if (state_q == S_CAPTURE) begin
                tag_q[upd_idx]   <= addr_q;
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q           <= 1'b1;
            done_q            <= 1'b0;
            hit_out_q         <= 1'b0;
            rdata_q           <= '0;
            mem_read_q        <= 1'b0;
            mem_endereco_q    <= '0;
            mem_wb_q          <= 1'b0;
            mem_endereco_wb_q <= '0;
            mem_dado_wb_q     <= '0;
        end else begin
            ready_q           <= (state_d == S_IDLE);
            done_q            <= (state_d == S_DONE);
            hit_out_q         <= (state_d == S_DONE) && (state_q == S_LOOKUP);
            rdata_q           <= (state_d == S_DONE) ? upd_data : '0;
            mem_read_q        <= (state_d == S_FILL);
            mem_endereco_q    <= (state_d == S_FILL) ? addr_q : '0;
            mem_wb_q          <= (state_d == S_WB);
            mem_endereco_wb_q <= (state_d == S_WB) ? tag_q[victim_idx] : '0;
            mem_dado_wb_q     <= (state_d == S_WB) ? data_q[victim_idx] : '0;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and random requests against a behavioural cache
// model (line arrays, recency queue or round-robin pointer, flat memory).
module tb_cache_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [2:0] wdata = 3'd0;
    logic [2:0] mem_dado = 3'd0;
    logic       ready, done, hit, mem_read, mem_wb;
    logic [2:0] rdata, mem_endereco, mem_endereco_wb, mem_dado_wb;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cache_ctrl #(.LINES(4), .ADDR_W(3), .DATA_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ready(ready), .done(done), .hit(hit), .rdata(rdata),
        .mem_endereco(mem_endereco), .mem_read(mem_read), .mem_dado(mem_dado),
        .mem_endereco_wb(mem_endereco_wb), .mem_dado_wb(mem_dado_wb),
        .mem_wb(mem_wb)
    );

    // Backing memory: read data one cycle after mem_read, honours write-backs.
    logic [2:0] bmem [8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0};
    always @(posedge clock) begin
        if (mem_read) mem_dado <= bmem[mem_endereco];
        if (mem_wb) bmem[mem_endereco_wb] <= mem_dado_wb;
    end

    // Reference model state.
    bit m_valid [4];
    bit m_dirty [4];
    int m_tag   [4];
    int m_data  [4];
    int m_mem   [8];
    int lru_q [$];   // most recently used at the front
    int rr_ptr;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp_v, input string tag);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        lru_q.delete();
        rr_ptr = 0;
    endfunction

    function automatic bit resident(input int a);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Predicts one access and advances the model's cache state.
    function automatic void predict(input bit w, input int a, input int wd,
                                    output bit eh, output int er,
                                    output bit ewb, output int ewa, output int ewd);
        int idx = -1;
        eh = 1'b0; ewb = 1'b0; ewa = 0; ewd = 0;
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == a) idx = i;
        if (idx >= 0) begin
            eh = 1'b1;
        end else begin
            for (int i = 3; i >= 0; i--)
                if (!m_valid[i]) idx = i;
            if (idx < 0) begin
`ifdef CACHE_LRU_EN
                idx = lru_q[$];
`else
                idx = rr_ptr;
                rr_ptr = (rr_ptr + 1) % 4;
`endif
            end
            if (m_valid[idx] && m_dirty[idx]) begin
                ewb = 1'b1;
                ewa = m_tag[idx];
                ewd = m_data[idx];
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a;
            m_data[idx]  = m_mem[a];
            m_dirty[idx] = 1'b0;
        end
        if (w) begin
            m_data[idx]  = wd;
            m_dirty[idx] = 1'b1;
        end
        er = m_data[idx];
        for (int i = 0; i < lru_q.size(); i++)
            if (lru_q[i] == idx) begin
                lru_q.delete(i);
                break;
            end
        lru_q.push_front(idx);
    endfunction

    // One request: drive in an idle cycle, then check every cycle up to done.
    // With hold set, req stays high carrying the next request's values.
    task automatic txn(input bit w, input int a, input int wd,
                       input bit hold, input bit hw, input int ha, input int hwd);
        bit eh, ewb;
        int er, ewa, ewd, lat, rdc, wbc;
        @(negedge clock);
        chk(32'(ready), 32'(1), "ready_idle");
        req = 1'b1; we = w; addr = 3'(a); wdata = 3'(wd);
        predict(w, a, wd, eh, er, ewb, ewa, ewd);
        lat = eh ? 2 : (ewb ? 5 : 4);
        rdc = eh ? 0 : (ewb ? 3 : 2);
        wbc = ewb ? 2 : 0;
        @(posedge clock);
        #1;
        if (hold) begin
            we = hw; addr = 3'(ha); wdata = 3'(hwd);
        end else begin
            req = 1'b0;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            chk(32'(done), 32'(k == lat), "done");
            chk(32'(mem_read), 32'(k == rdc), "mem_read");
            chk(32'(mem_endereco), (k == rdc) ? 32'(a) : 32'(0), "mem_endereco");
            chk(32'(mem_wb), 32'(k == wbc), "mem_wb");
            chk(32'(mem_endereco_wb), (k == wbc) ? 32'(ewa) : 32'(0), "mem_endereco_wb");
            chk(32'(mem_dado_wb), (k == wbc) ? 32'(ewd) : 32'(0), "mem_dado_wb");
            if (k == lat) begin
                chk(32'(hit), 32'(eh), "hit");
                chk(32'(rdata), 32'(er), "rdata");
            end
        end
        if (ewb) m_mem[ewa] = ewd;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(32'(ready), 32'(1), {tag, "_ready"});
        chk(32'(done), 32'(0), {tag, "_done"});
        chk(32'(hit), 32'(0), {tag, "_hit"});
        chk(32'(rdata), 32'(0), {tag, "_rdata"});
        chk(32'(mem_read), 32'(0), {tag, "_mem_read"});
        chk(32'(mem_wb), 32'(0), {tag, "_mem_wb"});
        chk(32'(mem_endereco), 32'(0), {tag, "_mem_endereco"});
        chk(32'(mem_endereco_wb), 32'(0), {tag, "_mem_endereco_wb"});
        chk(32'(mem_dado_wb), 32'(0), {tag, "_mem_dado_wb"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int miss_a, ha;
        bit pend, pw, hold;
        int pa, pwd, nw, na, nwd;

        m_mem = '{0, 0, 1, 2, 3, 3, 4, 0};
        model_reset();

        // Reset and reset values.
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("rst");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_reset_outputs("post_rst");

        // Directed sequence.
        txn(0, 3, 0, 0, 0, 0, 0);   // clean miss, rdata 2
        txn(0, 3, 0, 0, 0, 0, 0);   // hit
        txn(1, 4, 7, 0, 0, 0, 0);   // write miss
        txn(0, 4, 0, 0, 0, 0, 0);   // read hit, 7
        txn(0, 2, 0, 0, 0, 0, 0);
        txn(0, 6, 0, 0, 0, 0, 0);   // cache full
        txn(0, 3, 0, 0, 0, 0, 0);
        txn(0, 2, 0, 0, 0, 0, 0);
        txn(0, 6, 0, 0, 0, 0, 0);
        txn(0, 5, 0, 0, 0, 0, 0);   // replacement decides victim

        // Dirty every resident line, then reset during the write-back cycle.
        for (int i = 0; i < 4; i++)
            txn(1, m_tag[i], int'($urandom_range(0, 7)), 0, 0, 0, 0);
        miss_a = 0;
        while (resident(miss_a)) miss_a++;
        @(negedge clock);
        chk(32'(ready), 32'(1), "abort_ready");
        req = 1'b1; we = 1'b0; addr = 3'(miss_a);
        @(posedge clock);
        #1 req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk(32'(mem_wb), 32'(1), "abort_wb_cycle");
        reset_n = 1'b0;
        #1 chk_reset_outputs("abort");
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        txn(0, 4, 0, 0, 0, 0, 0);   // miss after reset returns memory contents

        // Held req through a miss: only the first is serviced until ready.
        miss_a = 0;
        while (resident(miss_a)) miss_a++;
        ha = (miss_a + 3) % 8;
        txn(0, miss_a, 0, 1, 1, ha, 5);
        txn(1, ha, 5, 0, 0, 0, 0);

        // Random phase, with occasional held requests.
        pend = 1'b0; pw = 1'b0; pa = 0; pwd = 0;
        for (int t = 0; t < 120; t++) begin
            if (pend) begin
                nw = pw; na = pa; nwd = pwd;
            end else begin
                nw  = ($urandom_range(0, 9) < 4) ? 1 : 0;
                na  = int'($urandom_range(0, 7));
                nwd = int'($urandom_range(0, 7));
            end
            hold = ($urandom_range(0, 7) == 0);
            pw  = ($urandom_range(0, 1) == 1);
            pa  = int'($urandom_range(0, 7));
            pwd = int'($urandom_range(0, 7));
            txn(nw[0], na, nwd, hold, pw, pa, pwd);
            pend = hold;
        end
        if (pend) txn(pw, pa, pwd, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
